// File: rtl/tff_toggle_gen.sv
//------------------------------------------------------------------------------
// tff_toggle_gen -- synchronises and debounces a push-button into one-cycle
// toggle pulses for a T flip-flop. Optional macro: TOGGLE_AUTOREPEAT_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tff_toggle_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_CYCLES   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  output logic       t,
  output logic       busy,
  output logic [7:0] t_count
);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_DB_PRESS   = 2'd1,
    ST_HELD       = 2'd2,
    ST_DB_RELEASE = 2'd3
  } state_e;

  localparam logic [7:0] c_db_last = 8'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_chk_debounce
    $error("DEBOUNCE_CYCLES must be in 1..255");
  end
  if (REPEAT_CYCLES < 2 || REPEAT_CYCLES > 255) begin : g_chk_repeat
    $error("REPEAT_CYCLES must be in 2..255");
  end

  logic       sync1_q, sync2_q;
  logic       btn_s;
  state_e     state_q, state_d;
  logic [7:0] db_cnt_q, db_cnt_d;
  logic       t_q, t_d;
  logic       busy_q, busy_d;
  logic [7:0] t_count_q, t_count_d;
  logic       pulse;

`ifdef TOGGLE_AUTOREPEAT_EN
  localparam logic [7:0] c_rep_last = 8'(REPEAT_CYCLES - 1);
  logic [7:0] rep_cnt_q, rep_cnt_d;
`endif

  assign btn_s = sync2_q;

  always_comb begin
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    pulse    = 1'b0;
`ifdef TOGGLE_AUTOREPEAT_EN
    rep_cnt_d = rep_cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (btn_s) begin
          state_d  = ST_DB_PRESS;
          db_cnt_d = 8'd0;
        end
      end
      ST_DB_PRESS: begin
        if (!btn_s) begin
          state_d = ST_IDLE;
        end else if (db_cnt_q == c_db_last) begin
          state_d = ST_HELD;
          pulse   = 1'b1;
`ifdef TOGGLE_AUTOREPEAT_EN
          rep_cnt_d = 8'd0;
`endif
        end else begin
          db_cnt_d = db_cnt_q + 8'd1;
        end
      end
      ST_HELD: begin
        if (!btn_s) begin
          state_d  = ST_DB_RELEASE;
          db_cnt_d = 8'd0;
        end
`ifdef TOGGLE_AUTOREPEAT_EN
        else if (rep_cnt_q == c_rep_last) begin
          pulse     = 1'b1;
          rep_cnt_d = 8'd0;
        end else begin
          rep_cnt_d = rep_cnt_q + 8'd1;
        end
`endif
      end
      ST_DB_RELEASE: begin
        // A high sample here is a release bounce: back to HELD, no pulse.
        if (btn_s) begin
          state_d = ST_HELD;
`ifdef TOGGLE_AUTOREPEAT_EN
          rep_cnt_d = 8'd0;
`endif
        end else if (db_cnt_q == c_db_last) begin
          state_d = ST_IDLE;
        end else begin
          db_cnt_d = db_cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    t_d       = pulse;
    t_count_d = t_count_q + {7'd0, pulse};
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= ST_IDLE;
      db_cnt_q  <= 8'd0;
      t_q       <= 1'b0;
      busy_q    <= 1'b0;
      t_count_q <= 8'd0;
`ifdef TOGGLE_AUTOREPEAT_EN
      rep_cnt_q <= 8'd0;
`endif
    end else begin
      sync1_q   <= btn;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      db_cnt_q  <= db_cnt_d;
      t_q       <= t_d;
      busy_q    <= busy_d;
      t_count_q <= t_count_d;
`ifdef TOGGLE_AUTOREPEAT_EN
      rep_cnt_q <= rep_cnt_d;
`endif
    end
  end

  assign t       = t_q;
  assign busy    = busy_q;
  assign t_count = t_count_q;

endmodule

`default_nettype wire

// File: tb/tb_tff_toggle_gen.sv
//------------------------------------------------------------------------------
// tb_tff_toggle_gen -- self-checking bench for tff_toggle_gen.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_tff_toggle_gen;

  localparam int D = 4;
  localparam int R = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn = 1'b0;
  logic       t;
  logic       busy;
  logic [7:0] t_count;

  int n_cmp = 0;
  int n_bad = 0;
  int n_pulse = 0;

  tff_toggle_gen #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R)) dut (
    .clk     (clk),
    .rst     (rst),
    .btn     (btn),
    .t       (t),
    .busy    (busy),
    .t_count (t_count)
  );

  always #5 clk = ~clk;

  // Reference model: accepted level plus the length of the current run of
  // synchronised samples disagreeing with it; a run of D+1 flips the level.
  logic       m_s1, m_s2;
  logic       m_lvl;
  int         m_run;
  int         m_age;
  logic       m_t, m_busy;
  logic [7:0] m_cnt;

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_lvl = 0; m_run = 0; m_age = 0;
    m_t = 0; m_busy = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    logic s;
    s    = m_s2;
    m_s2 = m_s1;
    m_s1 = btn;
    m_t  = 0;
    if (s != m_lvl) begin
      m_run++;
      if (m_run == D + 1) begin
        m_lvl = s;
        m_run = 0;
        m_age = 0;
        if (s) begin
          m_t = 1;
          m_cnt++;
        end
      end
    end else begin
      if (m_lvl && m_run > 0) begin
        m_age = 0;
      end else if (m_lvl) begin
`ifdef TOGGLE_AUTOREPEAT_EN
        m_age++;
        if (m_age == R) begin
          m_age = 0;
          m_t   = 1;
          m_cnt++;
        end
`endif
      end
      m_run = 0;
    end
    m_busy = m_lvl || (m_run > 0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("t", {31'd0, t}, {31'd0, m_t});
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    chk("t_count", {24'd0, t_count}, {24'd0, m_cnt});
  endtask

  task automatic step(input logic b);
    btn = b;
    @(posedge clk);
    model_edge();
    #1;
    if (t === 1'b1) n_pulse++;
    chk_model();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    model_reset();
    #1;
    chk_model();
    repeat (n) begin
      @(posedge clk);
      #1;
      chk("rst_t", {31'd0, t}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_cnt", {24'd0, t_count}, 32'd0);
    end
    rst = 1'b1;
  endtask

  typedef struct {
    logic       b;
    logic       t;
    logic       busy;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[18];

  initial begin
    int first_t;
    int base;
    logic lvl;
    logic seen255, seen0;

    // Clean press/release: btn high for 10 edges, t at E6, busy E2..E15.
    for (int i = 0; i < 18; i++) begin
      tbl[i].b    = (i < 10);
      tbl[i].t    = (i == 6);
      tbl[i].busy = (i >= 2 && i < 16);
      tbl[i].cnt  = (i >= 6) ? 8'd1 : 8'd0;
    end

    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // Reset held with button pressed, then the press must re-debounce.
    btn = 1'b1;
    do_reset(3);
    first_t = -1;
    for (int i = 0; i < 10; i++) begin
      step(1'b1);
      if (t === 1'b1 && first_t < 0) first_t = i;
    end
    chk("rst_press_edge", first_t, 32'd6);
    repeat (12) step(1'b0);

    // Table-driven clean press and release.
    do_reset(1);
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].b);
      chk("tbl_t", {31'd0, t}, {31'd0, tbl[i].t});
      chk("tbl_busy", {31'd0, busy}, {31'd0, tbl[i].busy});
      chk("tbl_cnt", {24'd0, t_count}, {24'd0, tbl[i].cnt});
    end

    // Press bounce 1,1,0,1,0 is rejected, then a solid press is accepted.
    do_reset(1);
    base = n_pulse;
    step(1); step(1); step(0); step(1); step(0);
    repeat (10) step(1'b0);
    chk("bounce_pulses", n_pulse - base, 32'd0);
    chk("bounce_cnt", {24'd0, t_count}, 32'd0);
    repeat (10) step(1'b1);
    chk("press_pulses", n_pulse - base, 32'd1);

    // Release bounce while held: no extra pulse, stays busy.
    base = n_pulse;
    step(0); step(0);
    repeat (8) begin
      step(1'b1);
      chk("relb_busy", {31'd0, busy}, 32'd1);
    end
    chk("relb_pulses", n_pulse - base, 32'd0);
    chk("relb_cnt", {24'd0, t_count}, 32'd1);
    repeat (10) step(1'b0);

    // Hold for 40 cycles past the first pulse.
    do_reset(1);
    base = n_pulse;
    repeat (46) step(1'b1);
    repeat (12) step(1'b0);
`ifdef TOGGLE_AUTOREPEAT_EN
    chk("repeat_pulses", n_pulse - base, 32'd6);
`else
    chk("repeat_pulses", n_pulse - base, 32'd1);
`endif

    // 257 accepted presses wrap the counter to 1.
    do_reset(1);
    seen255 = 0;
    seen0   = 0;
    for (int p = 0; p < 257; p++) begin
      repeat (8) step(1'b1);
      if (t_count == 8'd255) seen255 = 1;
      if (seen255 && t_count == 8'd0) seen0 = 1;
      repeat (8) step(1'b0);
    end
    chk("wrap_cnt", {24'd0, t_count}, 32'd1);
    chk("wrap_seen", {30'd0, seen255, seen0}, 32'd3);

    // Random bursts with occasional asynchronous resets.
    lvl = 1'b0;
    for (int r = 0; r < 300; r++) begin
      if ($urandom_range(0, 39) == 0) do_reset($urandom_range(1, 3));
      lvl = ~lvl;
      repeat ($urandom_range(1, 12)) step(lvl);
    end
    repeat (12) step(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
